// File: rtl/reg_port_arbiter_pkg.sv
// Shared bus type, FSM state encoding and widths for the register-port arbiter.
// Build option: define REG_ARB_RR_EN for round-robin grants (fixed priority otherwise).
package reg_port_arbiter_pkg;

  localparam int REG_SEL_W  = 3;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_DATA_W-1:0] data;
    logic [REG_SEL_W-1:0]  sel;
    logic                  mode;  // 1 = write, 0 = read/idle
  } reg_in_bus_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    RESP
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to four requesters.
  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    oh_to_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) oh_to_idx = 2'(k);
    end
  endfunction

endpackage

// File: rtl/reg_port_arbiter_rr_arbiter.sv
// One-hot grant generator for NREQ requesters.
// REG_ARB_RR_EN defined: rotating priority starting just above the last winner; else lowest index wins.
module rr_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
`ifdef REG_ARB_RR_EN
  input  logic            clk,
  input  logic            reset,
  input  logic            accept,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] w_pool;
  logic            w_found;

`ifdef REG_ARB_RR_EN
  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] r_ptr;
  logic [NREQ-1:0]  w_mask;
  logic [NREQ-1:0]  w_masked;
  logic [1:0]       w_win;

  // Requests at or above the pointer get first pick; fall back to all requests on wrap.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_mask[k] = (k >= int'(r_ptr));
    end
  end

  assign w_masked = req & w_mask;
  assign w_pool   = (|w_masked) ? w_masked : req;
  assign w_win    = oh_to_idx(4'(grant));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= (int'(w_win) == NREQ - 1) ? '0 : PTR_W'(w_win + 2'd1);
    end
  end
`else
  assign w_pool = req;
`endif

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      grant[k] = w_pool[k] & ~w_found;
      w_found  = w_found | w_pool[k];
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Arbitrates NREQ requesters onto a single register-bank port, one transaction in flight.
// Build option: REG_ARB_RR_EN selects round-robin arbitration in rr_arbiter.
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int READ_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*REG_SEL_W-1:0]  req_sel,
  input  logic [NREQ*REG_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [REG_DATA_W-1:0]      rsp_data,
  output reg_in_bus_t                rb_bus,
  output logic                       rb_en,
  output logic                       rb_rst,
  input  logic [REG_DATA_W-1:0]      rb_q,
  output logic                       busy
);

  localparam int CNT_W = 2;

  arb_state_t              r_state;
  logic [NREQ-1:0]         r_grant;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_rb_en;
  reg_in_bus_t             r_rb_bus;
  logic [NREQ-1:0]         r_rsp_valid;
  logic [REG_DATA_W-1:0]   r_rsp_data;
  logic                    r_busy;

  logic [NREQ-1:0]         w_grant;
  logic                    w_accept;
  reg_in_bus_t             w_bus;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
`ifdef REG_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
    .accept (w_accept),
`endif
    .req    (req_valid),
    .grant  (w_grant)
  );

  // Grant is only visible in IDLE and out of reset, so at most one request is taken.
  assign req_ready = (reset && r_state == IDLE) ? w_grant : '0;
  assign w_accept  = |req_ready;

  always_comb begin
    w_bus = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_bus.data = req_data[k*REG_DATA_W +: REG_DATA_W];
        w_bus.sel  = req_sel[k*REG_SEL_W +: REG_SEL_W];
        w_bus.mode = req_write[k];
      end
    end
  end

  // The bus register itself holds the latched request; r_grant doubles as the response pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_rb_en     <= 1'b0;
      r_rb_bus    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant  <= w_grant;
            r_rb_en  <= 1'b1;
            r_rb_bus <= w_bus;
            r_busy   <= 1'b1;
            r_state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_rb_bus.mode) begin
            r_rsp_data  <= r_rb_bus.data;
            r_rsp_valid <= r_grant;
            r_rb_en     <= 1'b0;
            r_rb_bus    <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(READ_LAT - 1)) begin
            r_rsp_data  <= rb_q;
            r_rsp_valid <= r_grant;
            r_rb_en     <= 1'b0;
            r_rb_bus    <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (|(r_rsp_valid & rsp_ready)) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rb_bus    = r_rb_bus;
  assign rb_en     = r_rb_en;
  assign busy      = r_busy;
  assign rb_rst    = ~reset;

endmodule
